// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and a programmable baud divisor.
// Optional interrupt output and IE register are built when UART_TX_MMIO_IRQ_EN is defined.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        store,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        tx
`ifdef UART_TX_MMIO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, next_state;

  logic          sel;
  logic [1:0]    reg_idx;
  logic          wr_txdata, wr_status, wr_div;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full, fifo_empty;
  logic          push_ok, pop;

  logic          overflow;
  logic [15:0]   div_reg;
  logic [15:0]   div_load;
  logic [15:0]   baud_cnt;
  logic          bit_done;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic          busy;
  logic [31:0]   count_ext;
  logic [3:0]    cnt_sat;
  logic          unused_bits;

  assign sel       = (address[31:4] == BASE_ADDR[31:4]);
  assign reg_idx   = address[3:2];
  assign wr_txdata = store & sel & (reg_idx == 2'd0);
  assign wr_status = store & sel & (reg_idx == 2'd1);
  assign wr_div    = store & sel & (reg_idx == 2'd2);

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign push_ok    = wr_txdata & (~fifo_full | pop);

  assign div_load = (div_reg == 16'd0) ? 16'd0 : (div_reg - 16'd1);
  assign bit_done = (baud_cnt == 16'd0);
  assign busy     = (state != IDLE);

  assign count_ext = 32'(count);
  assign cnt_sat   = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

  assign unused_bits = ^{address[1:0], store_data[31:16]};

  // FIFO storage carries no reset; validity is tracked by count.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= store_data[7:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      div_reg  <= DIV_RESET;
    end else begin
      if (wr_txdata && fifo_full && !pop) begin
        overflow <= 1'b1;
      end else if (wr_status && store_data[3]) begin
        overflow <= 1'b0;
      end
      if (wr_div) begin
        div_reg <= store_data[15:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    tx         = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_done) begin
          next_state = DATA;
        end
      end
      DATA: begin
        tx = shift[0];
        if (bit_done && (bit_idx == 3'd7)) begin
          next_state = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            next_state = START;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The counter reloads from the live divisor at every bit boundary, so a
  // divisor write mid-frame first affects the following bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else if (pop) begin
      shift    <= mem[rd_ptr];
      bit_idx  <= '0;
      baud_cnt <= div_load;
    end else if (state != IDLE) begin
      if (bit_done) begin
        baud_cnt <= div_load;
        if (state == DATA) begin
          shift   <= shift >> 1;
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt - 16'd1;
      end
    end
  end

`ifdef UART_TX_MMIO_IRQ_EN
  logic ie;
  logic wr_ie;

  assign wr_ie = store & sel & (reg_idx == 2'd3);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr_ie) begin
        ie <= store_data[0];
      end
      irq <= ie & fifo_empty & (state == IDLE);
    end
  end
`endif

  always_comb begin
    load_data = '0;
    if (load && sel) begin
      case (reg_idx)
        2'd1:    load_data = {24'h0, cnt_sat, overflow, fifo_empty, fifo_full, busy};
        2'd2:    load_data = {16'h0, div_reg};
`ifdef UART_TX_MMIO_IRQ_EN
        2'd3:    load_data = {31'h0, ie};
`endif
        default: load_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register table plus frame-timing sequences.
// Exercises the IRQ path as well when UART_TX_MMIO_IRQ_EN is defined.
module tb_uart_tx_mmio;

  localparam logic [31:0] A_TX  = 32'h1000_0000;
  localparam logic [31:0] A_ST  = 32'h1000_0004;
  localparam logic [31:0] A_DIV = 32'h1000_0008;
  localparam logic [31:0] A_IE  = 32'h1000_000C;

  logic        clock;
  logic        reset;
  logic        load;
  logic        store;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        tx;
`ifdef UART_TX_MMIO_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic txlog [16384];

  uart_tx_mmio #(
    .BASE_ADDR (32'h1000_0000),
    .FIFO_DEPTH(4),
    .DIV_RESET (16'd868)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .store     (store),
    .address   (address),
    .store_data(store_data),
    .load_data (load_data),
    .tx        (tx)
`ifdef UART_TX_MMIO_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) txlog[cyc & 16383] = tx;

  initial begin
    #500us;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address    = a;
    store_data = d;
    store      = 1'b1;
    @(negedge clock);
    store      = 1'b0;
  endtask

  task automatic rd_check(input string nm, input logic [31:0] a, input logic [31:0] exp);
    address = a;
    load    = 1'b1;
    #1;
    check(nm, load_data, exp);
    load    = 1'b0;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int j, input int p0, input int p);
    int k;
    if (j < p0) return 1'b0;
    k = (j - p0) / p;
    if (k < 8) return b[k];
    return 1'b1;
  endfunction

  // s = cycle stamp of the first sample after the pop edge
  task automatic check_frame(input string nm, input logic [7:0] b, input int s,
                             input int p0, input int p);
    int len;
    int nbad;
    len  = p0 + 9 * p;
    nbad = 0;
    while (cyc < s + len) @(negedge clock);
    for (int j = 0; j < len; j++) begin
      if (txlog[(s + j) & 16383] !== frame_bit(b, j, p0, p)) nbad++;
    end
    check(nm, nbad, 0);
  endtask

  typedef struct {
    logic [1:0]  kind;  // 0 write, 1 read, 2 read with load low
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vt[14];

  initial begin
    int c;
    logic [31:0] ie_exp;

`ifdef UART_TX_MMIO_IRQ_EN
    ie_exp = 32'h1;
`else
    ie_exp = 32'h0;
`endif
    vt[0]  = '{2'd1, A_ST,  32'h0,         32'h4,   "rst_status"};
    vt[1]  = '{2'd1, A_DIV, 32'h0,         32'd868, "rst_div"};
    vt[2]  = '{2'd1, A_TX,  32'h0,         32'h0,   "txdata_reads0"};
    vt[3]  = '{2'd1, A_IE,  32'h0,         32'h0,   "rst_ie"};
    vt[4]  = '{2'd2, A_ST,  32'h0,         32'h0,   "noload_zero"};
    vt[5]  = '{2'd0, A_DIV, 32'hFFFF_0005, 32'h0,   ""};
    vt[6]  = '{2'd1, A_DIV, 32'h0,         32'h5,   "div_low16"};
    vt[7]  = '{2'd0, 32'h2000_0008, 32'h7, 32'h0,   ""};
    vt[8]  = '{2'd1, A_DIV, 32'h0,         32'h5,   "div_unselected_store"};
    vt[9]  = '{2'd1, 32'h2000_0004, 32'h0, 32'h0,   "unselected_read"};
    vt[10] = '{2'd1, 32'h1000_0006, 32'h0, 32'h4,   "byte_offset_ignored"};
    vt[11] = '{2'd0, A_IE,  32'h1,         32'h0,   ""};
    vt[12] = '{2'd1, A_IE,  32'h0,         ie_exp,  "ie_rw"};
    vt[13] = '{2'd0, A_IE,  32'h0,         32'h0,   ""};

    reset = 1'b0; load = 1'b0; store = 1'b0; address = '0; store_data = '0;
    repeat (3) @(negedge clock);
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_load_data", load_data, 32'h0);
`ifdef UART_TX_MMIO_IRQ_EN
    check("rst_irq", {31'h0, irq}, 32'h0);
`endif
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 14; i++) begin
      case (vt[i].kind)
        2'd0: wr(vt[i].addr, vt[i].data);
        2'd1: begin rd_check(vt[i].name, vt[i].addr, vt[i].exp); @(negedge clock); end
        default: begin
          address = vt[i].addr;
          #1;
          check(vt[i].name, load_data, vt[i].exp);
          @(negedge clock);
        end
      endcase
    end

    // single byte, DIV=4
    wr(A_DIV, 32'd4);
    c = cyc;
    wr(A_TX, 32'hA5);
    check("tx_before_pop", {31'h0, tx}, 32'h1);
    rd_check("status_before_pop", A_ST, 32'h10);
    @(negedge clock);
    rd_check("status_busy_empty", A_ST, 32'h05);
    check_frame("frame_a5", 8'hA5, c + 2, 4, 4);
    rd_check("status_after_a5", A_ST, 32'h04);

    // four back-to-back frames, DIV=2
    wr(A_DIV, 32'd2);
    c = cyc;
    for (int i = 1; i <= 4; i++) wr(A_TX, i);
    for (int i = 0; i < 4; i++) check_frame("frame_b2b", 8'(i + 1), c + 2 + 20 * i, 2, 2);
    rd_check("status_after_b2b", A_ST, 32'h04);

    // overflow, W1C, then reset mid-DATA
    wr(A_DIV, 32'd100);
    c = cyc;
    for (int i = 0; i < 6; i++) wr(A_TX, 32'h10 + 32'(i) * 32'h11);
    rd_check("status_overflow", A_ST, 32'h4B);
    wr(A_ST, 32'h8);
    rd_check("status_w1c", A_ST, 32'h43);
    while (cyc < c + 150) @(negedge clock);
    check("tx_mid_data", {31'h0, tx}, 32'h0);
    reset = 1'b0;
    #1;
    check("tx_async_reset", {31'h0, tx}, 32'h1);
    rd_check("status_in_reset", A_ST, 32'h04);
    rd_check("div_in_reset", A_DIV, 32'd868);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("tx_idle_after_reset", {31'h0, tx}, 32'h1);
    rd_check("status_after_reset", A_ST, 32'h04);

    // DIV=0 behaves as 1
    wr(A_DIV, 32'd0);
    c = cyc;
    wr(A_TX, 32'h3C);
    check_frame("frame_div0", 8'h3C, c + 2, 1, 1);
    rd_check("div0_readback", A_DIV, 32'h0);

    // divisor change lands at the next bit boundary
    wr(A_DIV, 32'd4);
    c = cyc;
    wr(A_TX, 32'h55);
    wr(A_DIV, 32'd8);
    check_frame("frame_div_change", 8'h55, c + 2, 4, 8);
    rd_check("status_after_div_change", A_ST, 32'h04);

    // simultaneous load and store returns pre-store value
    address = A_DIV; store_data = 32'd3; load = 1'b1; store = 1'b1;
    #1;
    check("rw_same_cycle", load_data, 32'd8);
    @(negedge clock);
    store = 1'b0;
    #1;
    check("rw_after_store", load_data, 32'd3);
    load = 1'b0;
    @(negedge clock);

`ifdef UART_TX_MMIO_IRQ_EN
    wr(A_DIV, 32'd2);
    wr(A_IE, 32'h1);
    @(negedge clock);
    check("irq_idle_high", {31'h0, irq}, 32'h1);
    c = cyc;
    wr(A_TX, 32'h81);
    @(negedge clock);
    check("irq_drop_after_push", {31'h0, irq}, 32'h0);
    while (cyc < c + 22) @(negedge clock);
    check("irq_low_stop_done", {31'h0, irq}, 32'h0);
    @(negedge clock);
    check("irq_rise", {31'h0, irq}, 32'h1);
    wr(A_IE, 32'h0);
    @(negedge clock);
    check("irq_ie_cleared", {31'h0, irq}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
